// File: rtl/sev_seg_pkg.sv
// sev_seg_pkg: segment constants, hex-to-segment table and dwell derivation for the scan controller
package sev_seg_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [16*7-1:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  function automatic logic [6:0] hex_decode(input logic [3:0] h);
    return SEG_LUT[7*h +: 7];
  endfunction
  function automatic int dwell_cycles(input int clk_hz, input int dwell_hz);
    return clk_hz / dwell_hz;
  endfunction
endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex digit (hex) to active-low {g,f,e,d,c,b,a} pattern (seg)
module seg_hex_decode
  import sev_seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = hex_decode(hex);
endmodule

// File: rtl/sev_seg_scan_ctrl.sv
// sev_seg_scan_ctrl: 8-digit seven-segment scanner; ports clk, rst_n, digits, digit_en, update_req -> update_ack, an, ca, frame_tick; optional SEV_SEG_LEADING_ZERO_BLANK_EN
module sev_seg_scan_ctrl
  import sev_seg_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int DWELL_HZ   = 1000,
  parameter int GHOST_CYC  = 4,
  parameter int NUM_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    update_req,
  output logic                    update_ack,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              ca,
  output logic                    frame_tick
);
  localparam int DWELL = dwell_cycles(CLK_HZ, DWELL_HZ);
  localparam int CW = $clog2(DWELL);
  localparam int IW = $clog2(NUM_DIGITS);
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [4*NUM_DIGITS-1:0] sh_dig;
  logic [NUM_DIGITS-1:0] sh_en, blank;
  logic [6:0] seg;
  logic wrap, lit;
  assign wrap = cnt == CW'(DWELL - 1);
  assign frame_tick = wrap && idx == IW'(NUM_DIGITS - 1);
  assign update_ack = frame_tick && update_req;
  assign lit = cnt >= CW'(GHOST_CYC) && sh_en[idx] && !blank[idx];
  seg_hex_decode u_dec (.hex(sh_dig[{idx, 2'b00} +: 4]), .seg(seg));
`ifdef SEV_SEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;
  logic z;
  // a digit is blanked while it and every digit above it are zero; digit 0 never blanks
  always_comb begin
    lz = '0;
    z = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      z = z && digits[4*i +: 4] == 4'd0;
      lz[i] = z;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) blank <= '0;
    else if (update_ack) blank <= lz;
`else
  assign blank = '0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      sh_dig <= '0;
      sh_en <= '0;
      an <= '1;
      ca <= SEG_BLANK;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
      if (update_ack) begin
        sh_dig <= digits;
        sh_en <= digit_en;
      end
      an <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
      ca <= lit ? seg : SEG_BLANK;
    end
  end
endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// tb_sev_seg_scan_ctrl: scoreboard bench for sev_seg_scan_ctrl with DWELL=8, GHOST=2, 8 digits
module tb_sev_seg_scan_ctrl;
  localparam int N = 8, DW = 8, G = 2;
  logic clk = 0, rst_n = 0, update_req = 0;
  logic [31:0] digits = '0;
  logic [7:0] digit_en = '0, an;
  logic [6:0] ca;
  logic update_ack, frame_tick;
  int checks = 0, failures = 0, acks = 0, ticks = 0;
  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int m_cnt, m_idx;
  logic [31:0] m_dig;
  logic [7:0] m_en;
  logic [14:0] q [$];
  always #5 clk = ~clk;
  sev_seg_scan_ctrl #(.CLK_HZ(16), .DWELL_HZ(2), .GHOST_CYC(G), .NUM_DIGITS(N)) dut (
    .clk(clk), .rst_n(rst_n), .digits(digits), .digit_en(digit_en), .update_req(update_req),
    .update_ack(update_ack), .an(an), .ca(ca), .frame_tick(frame_tick)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] lz_mask(input logic [31:0] d);
    logic [7:0] m = '0;
`ifdef SEV_SEG_LEADING_ZERO_BLANK_EN
    logic z = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      z = z && d[4*i +: 4] == 4'd0;
      m[i] = z;
    end
`endif
    return m;
  endfunction
  task automatic mreset();
    m_cnt = 0;
    m_idx = 0;
    m_dig = '0;
    m_en = '0;
    q.delete();
  endtask
  task automatic tick();
    logic exp_ft, exp_ack, lit;
    logic [7:0] ea;
    logic [6:0] ec;
    logic [14:0] e;
    #1;
    exp_ft = m_cnt == DW - 1 && m_idx == N - 1;
    exp_ack = exp_ft && update_req;
    check("frame_tick", frame_tick, exp_ft);
    check("update_ack", update_ack, exp_ack);
    if (frame_tick) ticks++;
    if (update_ack) acks++;
    lit = m_cnt >= G && m_en[m_idx];
    ea = lit ? ~(8'b1 << m_idx) : 8'hFF;
    ec = lit ? tbl[m_dig[4*m_idx +: 4]] : 7'h7F;
    q.push_back({ea, ec});
    if (exp_ack) begin
      m_dig = digits;
      m_en = digit_en & ~lz_mask(digits);
    end
    if (m_cnt == DW - 1) begin
      m_cnt = 0;
      m_idx = (m_idx + 1) % N;
    end else m_cnt++;
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("an", an, e[14:7]);
    check("ca", ca, e[6:0]);
    check("an_onehot", $countones(~an) <= 1, 1);
    @(negedge clk);
  endtask
  task automatic run(input int n);
    repeat (n) tick();
  endtask
  task automatic wait_ack(input int bound);
    int a0 = acks, k = 0;
    while (acks == a0 && k < bound) begin
      tick();
      k++;
    end
    check("ack_seen", acks - a0, 1);
  endtask
  task automatic check_dark(input string tag);
    check({tag, "_an"}, an, 8'hFF);
    check({tag, "_ca"}, ca, 7'h7F);
    check({tag, "_ack"}, update_ack, 0);
    check({tag, "_ft"}, frame_tick, 0);
  endtask
  initial begin
    int a0;
    mreset();
    update_req = 1;
    repeat (3) @(negedge clk);
    #1 check_dark("reset");
    update_req = 0;
    @(negedge clk) rst_n = 1;
    run(192);
    check("ticks_3frames", ticks, 3);
    digits = 32'h01234567;
    digit_en = 8'hFF;
    update_req = 1;
    wait_ack(70);
    update_req = 0;
    run(64);
    digit_en = 8'hAA;
    update_req = 1;
    wait_ack(70);
    update_req = 0;
    run(64);
    run(5);
    digits = 32'hFEDCBA98;
    digit_en = 8'hFF;
    update_req = 1;
    a0 = acks;
    run(25);
    update_req = 0;
    run(64);
    check("dropped_req_acks", acks - a0, 0);
    update_req = 1;
    a0 = acks;
    run(192);
    check("held_req_acks", acks - a0, 3);
    run(5);
    rst_n = 0;
    #1 check_dark("midreset");
    mreset();
    @(negedge clk);
    #1 check_dark("midreset_hold");
    @(negedge clk) rst_n = 1;
    update_req = 0;
    run(64);
`ifdef SEV_SEG_LEADING_ZERO_BLANK_EN
    digits = 32'h00000450;
    digit_en = 8'hFF;
    update_req = 1;
    wait_ack(70);
    update_req = 0;
    run(64);
    digits = 32'h0;
    update_req = 1;
    wait_ack(70);
    update_req = 0;
    run(64);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
